// File: rtl/dmem_arbiter.sv
// Data-memory arbiter between the pipeline memory stage and the host port.
// Adds starvation-bounded host access and a halt mode that gives the host exclusive ownership.

// Per-port read return: a one-cycle rvalid, with rdata passing memory data through and holding it afterwards.
module dmem_rd_port #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ret,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rvalid,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] held;

  // A return that lines up with reset is dropped, not delivered.
  assign rvalid = ret && !reset;
  assign rdata  = rvalid ? mem_rdata : held;

  always_ff @(posedge clk) begin
    if (reset)       held <= '0;
    else if (rvalid) held <= mem_rdata;
  end
endmodule

module dmem_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_stall,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_rvalid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  input  logic              host_halt,
  output logic              host_halted,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
  localparam int NUM_PORTS = 2;  // 0 = CPU, 1 = host

  typedef enum logic [1:0] {SHARE, DRAIN, HALTED} state_t;
  typedef enum logic [1:0] {OWN_NONE, OWN_CPU, OWN_HOST} owner_t;

  state_t state, state_nxt, arb_state;
  owner_t rd_owner, rd_owner_nxt;
  logic [3:0] wait_cnt, wait_nxt, arb_wait;
  logic       starved;
  logic       cpu_granted, host_granted;

  logic [NUM_PORTS-1:0]             ret;
  logic [NUM_PORTS-1:0]             rvalid_v;
  logic [NUM_PORTS-1:0][DATA_W-1:0] rdata_v;

  // While reset is held, arbitrate as if already in SHARE with an empty wait count.
  assign arb_state = reset ? SHARE : state;
  assign arb_wait  = reset ? 4'd0 : wait_cnt;
  assign starved   = (arb_wait == 4'(STARVE_MAX));

  always_ff @(posedge clk) begin
    if (reset) state <= SHARE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      SHARE:   if (host_halt) state_nxt = DRAIN;
      DRAIN:   state_nxt = HALTED;
      HALTED:  if (!host_halt) state_nxt = SHARE;
      default: state_nxt = SHARE;
    endcase
  end

  always_comb begin
    cpu_granted  = 1'b0;
    host_granted = 1'b0;
    host_halted  = 1'b0;
    case (arb_state)
      SHARE: begin
        cpu_granted  = cpu_req && !(host_req && starved);
        host_granted = host_req && !cpu_granted;
      end
      DRAIN: host_granted = host_req;
      HALTED: begin
        host_granted = host_req;
        host_halted  = 1'b1;
      end
      default: ;
    endcase
  end

  assign cpu_stall = cpu_req && !cpu_granted;
  assign host_gnt  = host_req && host_granted;

  // The CPU drives the memory bus whenever the host is not granted.
  always_comb begin
    if (host_granted) begin
      mem_we    = host_we;
      mem_addr  = host_addr;
      mem_wdata = host_wdata;
    end else begin
      mem_we    = cpu_granted && cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  // Counts only losing host cycles in SHARE; any grant, idle host or other state zeroes it.
  always_comb begin
    wait_nxt = 4'd0;
    if (arb_state == SHARE && host_req && !host_granted)
      wait_nxt = starved ? arb_wait : arb_wait + 4'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) wait_cnt <= 4'd0;
    else       wait_cnt <= wait_nxt;
  end

  always_comb begin
    rd_owner_nxt = OWN_NONE;
    if (cpu_granted && !cpu_we)        rd_owner_nxt = OWN_CPU;
    else if (host_granted && !host_we) rd_owner_nxt = OWN_HOST;
  end

  always_ff @(posedge clk) begin
    if (reset) rd_owner <= OWN_NONE;
    else       rd_owner <= rd_owner_nxt;
  end

  assign ret[0] = (rd_owner == OWN_CPU);
  assign ret[1] = (rd_owner == OWN_HOST);

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
    dmem_rd_port #(.DATA_W(DATA_W)) u_rd (
      .clk       (clk),
      .reset     (reset),
      .ret       (ret[p]),
      .mem_rdata (mem_rdata),
      .rvalid    (rvalid_v[p]),
      .rdata     (rdata_v[p])
    );
  end

  assign cpu_rvalid  = rvalid_v[0];
  assign cpu_rdata   = rdata_v[0];
  assign host_rvalid = rvalid_v[1];
  assign host_rdata  = rdata_v[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed, table-driven bench for dmem_arbiter with a small synchronous-read memory model.
module tb_dmem_arbiter;
  localparam logic N = 1'b0;
  localparam logic Y = 1'b1;
  localparam logic [31:0] DB = 32'hDEADBEEF;
  localparam logic [31:0] Z  = 32'h0;

  bit clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        cpu_req, cpu_we, host_req, host_we, host_halt;
  logic [31:0] cpu_addr, cpu_wdata, host_addr, host_wdata;
  logic        cpu_stall, cpu_rvalid, host_gnt, host_rvalid, host_halted, mem_we;
  logic [31:0] cpu_rdata, host_rdata, mem_addr, mem_wdata, mem_rdata;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_MAX(4)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_rvalid(cpu_rvalid),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .host_halt(host_halt), .host_halted(host_halted),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Memory word k holds 0x1000_0000+k, except 0x10 which holds DEADBEEF.
  logic [31:0] mem [0:63];
  always @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 64; k++)
        mem[k] <= (k == 4) ? DB : (32'h1000_0000 | 32'(k));
    end else if (mem_we) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
    mem_rdata <= mem[mem_addr[7:2]];
  end

  typedef struct {
    logic c_req, c_we; logic [31:0] c_addr, c_wd;
    logic h_req, h_we; logic [31:0] h_addr, h_wd;
    logic halt;
    logic e_stall, e_hgnt, e_mwe; logic [31:0] e_maddr;
    logic e_crv; logic [31:0] e_crd;
    logic e_hrv; logic [31:0] e_hrd;
    logic e_halted;
  } vec_t;

  localparam int NV = 29;
  vec_t vt [NV];
  int nvec = 0;
  int miscompares = 0;

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL v%0d %s: got %h expected %h", idx, name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    cpu_req = v.c_req;  cpu_we = v.c_we;  cpu_addr = v.c_addr;  cpu_wdata = v.c_wd;
    host_req = v.h_req; host_we = v.h_we; host_addr = v.h_addr; host_wdata = v.h_wd;
    host_halt = v.halt;
  endtask

  task automatic idle();
    cpu_req = N; cpu_we = N; cpu_addr = Z; cpu_wdata = Z;
    host_req = N; host_we = N; host_addr = Z; host_wdata = Z; host_halt = N;
  endtask

  initial begin
    int n;
    logic got;
    // c_req c_we c_addr c_wd | h_req h_we h_addr h_wd | halt | stall hgnt mwe maddr | crv crd | hrv hrd | halted
    // CPU alone
    vt[0]  = '{N,N,Z,Z,            N,N,Z,Z,                N, N,N,N,Z,            N,Z,            N,Z,            N};
    vt[1]  = '{Y,N,32'h10,Z,       N,N,Z,Z,                N, N,N,N,32'h10,       N,Z,            N,Z,            N};
    vt[2]  = '{N,N,Z,Z,            N,N,Z,Z,                N, N,N,N,Z,            Y,DB,           N,Z,            N};
    // contention: CPU writes 0x40, host reads 0x44
    vt[3]  = '{Y,Y,32'h40,32'hC0,  Y,N,32'h44,Z,           N, N,N,Y,32'h40,       N,DB,           N,Z,            N};
    vt[4]  = '{Y,Y,32'h40,32'hC0,  Y,N,32'h44,Z,           N, N,N,Y,32'h40,       N,DB,           N,Z,            N};
    vt[5]  = '{Y,Y,32'h40,32'hC0,  Y,N,32'h44,Z,           N, N,N,Y,32'h40,       N,DB,           N,Z,            N};
    vt[6]  = '{Y,Y,32'h40,32'hC0,  Y,N,32'h44,Z,           N, N,N,Y,32'h40,       N,DB,           N,Z,            N};
    vt[7]  = '{Y,Y,32'h40,32'hC0,  Y,N,32'h44,Z,           N, Y,Y,N,32'h44,       N,DB,           N,Z,            N};
    vt[8]  = '{Y,Y,32'h40,32'hC0,  Y,N,32'h44,Z,           N, N,N,Y,32'h40,       N,DB,           Y,32'h10000011, N};
    vt[9]  = '{N,N,Z,Z,            N,N,Z,Z,                N, N,N,N,Z,            N,DB,           N,32'h10000011, N};
    // host write 0x20, then CPU read of it
    vt[10] = '{N,N,Z,Z,            Y,Y,32'h20,32'h12345678,N, N,Y,Y,32'h20,       N,DB,           N,32'h10000011, N};
    vt[11] = '{Y,N,32'h20,Z,       N,N,Z,Z,                N, N,N,N,32'h20,       N,DB,           N,32'h10000011, N};
    vt[12] = '{N,N,Z,Z,            N,N,Z,Z,                N, N,N,N,Z,            Y,32'h12345678, N,32'h10000011, N};
    // read in flight into DRAIN, halt mode, release
    vt[13] = '{Y,N,32'h10,Z,       N,N,Z,Z,                Y, N,N,N,32'h10,       N,32'h12345678, N,32'h10000011, N};
    vt[14] = '{Y,N,32'h24,Z,       N,N,Z,Z,                Y, Y,N,N,32'h24,       Y,DB,           N,32'h10000011, N};
    vt[15] = '{Y,N,32'h24,Z,       Y,N,32'h28,Z,           Y, Y,Y,N,32'h28,       N,DB,           N,32'h10000011, Y};
    vt[16] = '{Y,N,32'h24,Z,       Y,N,32'h10,Z,           Y, Y,Y,N,32'h10,       N,DB,           Y,32'h1000000A, Y};
    vt[17] = '{Y,N,32'h24,Z,       N,N,Z,Z,                N, Y,N,N,32'h24,       N,DB,           Y,DB,           Y};
    vt[18] = '{Y,N,32'h24,Z,       N,N,Z,Z,                N, N,N,N,32'h24,       N,DB,           N,DB,           N};
    vt[19] = '{N,N,Z,Z,            N,N,Z,Z,                N, N,N,N,Z,            Y,32'h10000009, N,DB,           N};
    // halt dropped while in DRAIN: still passes through HALTED for one cycle
    vt[20] = '{N,N,Z,Z,            N,N,Z,Z,                Y, N,N,N,Z,            N,32'h10000009, N,DB,           N};
    vt[21] = '{Y,N,32'h10,Z,       N,N,Z,Z,                N, Y,N,N,32'h10,       N,32'h10000009, N,DB,           N};
    vt[22] = '{Y,N,32'h10,Z,       N,N,Z,Z,                N, Y,N,N,32'h10,       N,32'h10000009, N,DB,           Y};
    vt[23] = '{Y,N,32'h10,Z,       N,N,Z,Z,                N, N,N,N,32'h10,       N,32'h10000009, N,DB,           N};
    vt[24] = '{N,N,Z,Z,            N,N,Z,Z,                N, N,N,N,Z,            Y,DB,           N,DB,           N};
    // back-to-back alternating reads
    vt[25] = '{N,N,Z,Z,            Y,N,32'h2C,Z,           N, N,Y,N,32'h2C,       N,DB,           N,DB,           N};
    vt[26] = '{Y,N,32'h30,Z,       N,N,Z,Z,                N, N,N,N,32'h30,       N,DB,           Y,32'h1000000B, N};
    vt[27] = '{N,N,Z,Z,            Y,N,32'h10,Z,           N, N,Y,N,32'h10,       Y,32'h1000000C, N,32'h1000000B, N};
    vt[28] = '{N,N,Z,Z,            N,N,Z,Z,                N, N,N,N,Z,            N,32'h1000000C, Y,DB,           N};

    reset = 1'b1;
    idle();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      drive(vt[i]);
      @(negedge clk);
      nvec++;
      chk("cpu_stall",   i, 32'(cpu_stall),   32'(vt[i].e_stall));
      chk("host_gnt",    i, 32'(host_gnt),    32'(vt[i].e_hgnt));
      chk("mem_we",      i, 32'(mem_we),      32'(vt[i].e_mwe));
      chk("mem_addr",    i, mem_addr,         vt[i].e_maddr);
      chk("cpu_rvalid",  i, 32'(cpu_rvalid),  32'(vt[i].e_crv));
      chk("cpu_rdata",   i, cpu_rdata,        vt[i].e_crd);
      chk("host_rvalid", i, 32'(host_rvalid), 32'(vt[i].e_hrv));
      chk("host_rdata",  i, host_rdata,       vt[i].e_hrd);
      chk("host_halted", i, 32'(host_halted), 32'(vt[i].e_halted));
      @(posedge clk);
      #1;
    end

    // Starvation bound: both ports writing continuously, host must win at the 5th cycle.
    cpu_req = Y; cpu_we = Y; cpu_addr = 32'h40; cpu_wdata = 32'h1;
    host_req = Y; host_we = Y; host_addr = 32'h48; host_wdata = 32'h2;
    n = -1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk);
      if (host_gnt) begin
        got = 1'b1;
        n = k;
      end
      @(posedge clk);
      #1;
    end
    nvec++;
    chk("starve_cycles", 100, 32'(n), 32'd4);
    @(negedge clk);
    nvec++;
    chk("post_force_cpu_stall", 101, 32'(cpu_stall), 32'd0);
    chk("post_force_host_gnt",  101, 32'(host_gnt),  32'd0);
    @(posedge clk);
    #1 idle();
    @(posedge clk);
    #1;

    // Reset while a host read is outstanding.
    host_req = Y; host_addr = 32'h2C;
    @(negedge clk);
    nvec++;
    chk("rst_seq_host_gnt", 110, 32'(host_gnt), 32'd1);
    @(posedge clk);
    #1 reset = 1'b1;
    cpu_req = Y; cpu_addr = 32'h30;
    @(negedge clk);
    nvec++;
    chk("rst_host_rvalid", 111, 32'(host_rvalid), 32'd0);
    chk("rst_cpu_stall",   111, 32'(cpu_stall),   32'd0);
    chk("rst_host_gnt",    111, 32'(host_gnt),    32'd0);
    chk("rst_mem_addr",    111, mem_addr,         32'h30);
    @(posedge clk);
    #1 reset = 1'b0;
    idle();
    @(negedge clk);
    nvec++;
    chk("post_rst_cpu_rvalid",  112, 32'(cpu_rvalid),  32'd0);
    chk("post_rst_host_rvalid", 112, 32'(host_rvalid), 32'd0);
    chk("post_rst_host_halted", 112, 32'(host_halted), 32'd0);
    chk("post_rst_cpu_rdata",   112, cpu_rdata,        32'd0);
    chk("post_rst_host_rdata",  112, host_rdata,       32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, miscompares);
    $finish;
  end
endmodule
